aes_inv_cipher_core: RTL and testbench
======================================

Name: aes_inv_cipher_core

Overview:
- Iterative AES-128 decryption core; the inverse of the existing AES_top encryption datapath.
- Accepts a 128-bit ciphertext and a 128-bit cipher key and produces the 128-bit plaintext using one round per clock.
- Expands the key forward into a round-key store, then applies rounds in reverse order.
- Caches the last expanded key so back-to-back blocks under the same key skip expansion.

Parameters:
- NR, 10, number of cipher rounds (AES-128 only; other values unsupported).
- KEY_CACHE_EN, 1, 1 = reuse the stored schedule when the key is unchanged; 0 = always re-expand.

Ports:
- AES_clk  input  1  system clock, rising edge.
- AES_rst  input  1  synchronous, active-high reset.
- AES_en  input  1  start strobe; sampled only in IDLE.
- AES_data_in  input  128  ciphertext, byte 0 in bits [127:120].
- AES_key_in  input  128  cipher key, same byte order.
- AES_data_out  output  128  plaintext; holds its value until the next result or reset.
- AES_data_out_valid  output  1  one-cycle pulse when AES_data_out updates.
- AES_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (AES_rst high at an edge, any state, including mid-operation):
  - state = IDLE; AES_data_out = 0; AES_data_out_valid = 0; AES_busy = 0.
  - Key-cache valid flag cleared; round counter = 0; round-key store contents are don't-care.
- States: IDLE, KEYEXP, INITADD, ROUND, DONE.
- IDLE, AES_en = 1 at edge T:
  - Capture AES_data_in into the state register and AES_key_in into rk[0].
  - If KEY_CACHE_EN and cache valid and AES_key_in equals the cached key, go to INITADD; otherwise go to KEYEXP with counter = 1.
- KEYEXP: one edge per round key.
  - rk[i] = FIPS-197 expansion of rk[i-1] (RotWord, SubWord, Rcon[i]).
  - After i = 10, set cache valid and go to INITADD.
- INITADD: state ^= rk[10]; counter = 9; go to ROUND.
- ROUND, counter r:
  - state = InvShiftRows, then InvSubBytes, then AddRoundKey(rk[r]).
  - Then InvMixColumns only if r != 0.
  - r decrements; when r = 0 completes, go to DONE.
- DONE (registered result):
  - AES_data_out = state; AES_data_out_valid = 1 for exactly this one cycle.
  - Next state is IDLE; AES_busy = 1 in this cycle.
- Latency, measured from the capture edge T to the first cycle with valid high:
  - 22 cycles with key expansion.
  - 12 cycles on a cache hit.
- Throughput: a new AES_en is accepted at the earliest in the cycle after the DONE cycle.
- AES_en while busy is ignored and never queued; inputs are don't-care outside the capture edge.
- AES_key_in changing mid-operation has no effect, because the key is captured at T.
- AES_en held high continuously: a new block starts every (latency + 1) cycles, each time with the inputs present at that IDLE edge.
- Rcon and the S-boxes are purely combinational; no multi-cycle paths.
- All arithmetic is GF(2^8) with polynomial 0x11B.
  - InvMixColumns matrix rows: {0e, 0b, 0d, 09}, rotated per row.

Decomposition:
- Shared package aes_pkg:
  - NR, Nk = 4.
  - The Rcon[1..10] array.
  - The state enum {IDLE, KEYEXP, INITADD, ROUND, DONE}.
  - GF functions xtime / gmul.
  - The byte-order convention.
- Forward S-box: reused from the encryption datapath, needed for key expansion.
- Sub-module aes_inv_round (combinational):
  - Inputs: state, round key, last-round flag.
  - Performs InvShiftRows, InvSubBytes, AddRoundKey and the optional InvMixColumns.
  - Contains the 16 inverse S-box instances.
- The core itself holds only the FSM, counter, rk[0..10] store, key cache and output registers.

Test Plan:
- FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32:
  - Required: AES_data_out = 3243f6a8885a308d313198a2e0370734, valid pulse exactly 22 cycles after the en edge, busy high throughout.
- FIPS-197 App. C.1, key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a:
  - Required: pt 00112233445566778899aabbccddeeff.
  - Then repeat the same key with ct 3925841d… under key 2b7e… re-applied → re-expansion occurs, latency 22.
- Cache hit: the C.1 key twice in a row, second ct = C.1 ct again:
  - Required: second result identical, latency 12; with KEY_CACHE_EN = 0 the latency is 22.
- AES_en pulsed every cycle while busy, with AES_data_in changed to a6f2daeb140fa720529e75d521cbc681 mid-operation:
  - Required: exactly one valid pulse, carrying the originally captured block's plaintext.
- AES_rst asserted in ROUND (counter = 5):
  - Required: next cycle AES_busy = 0, AES_data_out = 0, no valid pulse.
  - The following block under the same key takes 22 cycles (cache invalidated).
- Round-trip: encrypt a random block with AES_top, feed the ciphertext and key to this core:
  - Required: output equals the original plaintext.
  - Run 1000 random blocks with mixed key reuse, checked against a reference model.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers.
// Byte i of a 128-bit block sits at [127-8*i -: 8]; state is column-major, row = i % 4.
package aes_pkg;

  localparam int unsigned NumRounds = 10;
  localparam int unsigned Nk        = 4;

  // Rcon[1..10], Rcon[1] in the top byte
  localparam logic [79:0] RconTable = 80'h01_02_04_08_10_20_40_80_1b_36;

  typedef enum logic [2:0] {StIdle, StKeyExp, StInitAdd, StRound, StDone} aes_state_e;

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] acc = 8'h00;
    logic [7:0] p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(logic [7:0] x);
    logic [7:0] p   = x;
    logic [7:0] acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gmul(p, p);
      acc = gmul(acc, p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int unsigned n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(logic [3:0] i);
    if (i == 4'd0 || i > 4'd10) return 8'h00;
    return RconTable[79 - 8 * (int'(i) - 1) -: 8];
  endfunction

  function automatic logic [127:0] key_expand_step(logic [127:0] prev, logic [7:0] rc);
    logic [31:0] w [Nk];
    logic [31:0] t;
    for (int i = 0; i < Nk; i++) w[i] = prev[127 - 32 * i -: 32];
    t = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
        ^ {rc, 24'h0};
    w[0] = w[0] ^ t;
    for (int i = 1; i < Nk; i++) w[i] = w[i] ^ w[i - 1];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [31:0] inv_mix_col(logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// except in the final round, InvMixColumns.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  logic [127:0] sub, ark, mix;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int unsigned Row = i % 4;
    localparam int unsigned Col = i / 4;
    localparam int unsigned Src = ((Col + 4 - Row) % 4) * 4 + Row;
    assign sub[127 - 8 * i -: 8] = inv_sbox(state_i[127 - 8 * Src -: 8]);
  end

  assign ark = sub ^ rk_i;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign mix[127 - 32 * c -: 32] = inv_mix_col(ark[127 - 32 * c -: 32]);
  end

  assign state_o = last_i ? ark : mix;

endmodule

// File: rtl/aes_inv_cipher_core.sv
// Iterative AES-128 decryption: forward key expansion into rk[0..NR], then one inverse
// round per clock. The last expanded schedule is reused while the key stays the same.
module aes_inv_cipher_core
  import aes_pkg::*;
#(
  parameter int unsigned NR           = NumRounds,
  parameter bit          KEY_CACHE_EN = 1'b1
) (
  input  logic         AES_clk,
  input  logic         AES_rst,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  localparam logic [3:0] NrW = 4'(NR);

  aes_state_e   state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] out_q, out_d;
  logic         valid_q, valid_d;

  logic [3:0]   prev_idx;
  logic [127:0] next_rk, round_out;

  assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign next_rk  = key_expand_step(rk_q[prev_idx], rcon(cnt_q));

  aes_inv_round u_round (
    .state_i (data_q),
    .rk_i    (rk_q[cnt_q]),
    .last_i  (cnt_q == 4'd0),
    .state_o (round_out)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    rk_d        = rk_q;
    cache_vld_d = cache_vld_q;
    out_d       = out_q;
    valid_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (AES_en) begin
          data_d  = AES_data_in;
          rk_d[0] = AES_key_in;
          // rk[0] doubles as the cached key while the cache is valid
          if (KEY_CACHE_EN && cache_vld_q && (AES_key_in == rk_q[0])) begin
            state_d = StInitAdd;
          end else begin
            state_d     = StKeyExp;
            cnt_d       = 4'd1;
            cache_vld_d = 1'b0;
          end
        end
      end
      StKeyExp: begin
        rk_d[cnt_q] = next_rk;
        if (cnt_q == NrW) begin
          cache_vld_d = 1'b1;
          state_d     = StInitAdd;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StInitAdd: begin
        data_d  = data_q ^ rk_q[NR];
        cnt_d   = NrW - 4'd1;
        state_d = StRound;
      end
      StRound: begin
        data_d = round_out;
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StDone: begin
        out_d   = data_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      data_q      <= '0;
      cache_vld_q <= 1'b0;
      out_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      cache_vld_q <= cache_vld_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
    end
  end

  // Round-key store needs no reset; it is only read after being written
  always_ff @(posedge AES_clk) begin
    rk_q <= rk_d;
  end

  assign AES_data_out       = out_q;
  assign AES_data_out_valid = valid_q;
  assign AES_busy           = (state_q != StIdle);

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// Self-checking bench for aes_inv_cipher_core: FIPS-197 vectors, cache timing, enable
// while busy, mid-operation reset and random round-trips through a local AES encryptor.
module tb_aes_inv_cipher_core;

  localparam logic [127:0] KeyB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CtB    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PtB    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KeyC   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CtC    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PtC    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DinAlt = 128'ha6f2daeb140fa720529e75d521cbc681;

  logic         clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [127:0] din = '0, kin = '0;
  logic [127:0] dout, dout_nc;
  logic         vld, vld_nc, busy, busy_nc;

  int unsigned  cyc = 0, n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic [127:0] pt;
    logic [31:0]  t;
    logic [31:0]  lat;
  } exp_t;

  exp_t         sb[$], sb_nc[$];
  exp_t         m_e, m_e_nc;
  logic         cache_v_m = 1'b0;
  logic [127:0] cache_k_m = '0;
  logic [7:0]   sbox_t [256];

  aes_inv_cipher_core dut (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_en             (en),
    .AES_data_in        (din),
    .AES_key_in         (kin),
    .AES_data_out       (dout),
    .AES_data_out_valid (vld),
    .AES_busy           (busy)
  );

  aes_inv_cipher_core #(
    .KEY_CACHE_EN (1'b0)
  ) dut_nc (
    .AES_clk            (clk),
    .AES_rst            (rst),
    .AES_en             (en),
    .AES_data_in        (din),
    .AES_key_in         (kin),
    .AES_data_out       (dout_nc),
    .AES_data_out_valid (vld_nc),
    .AES_busy           (busy_nc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // ---- reference encryptor (independent of the DUT datapath) ----
  function automatic logic [7:0] m_xt(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ a;
      a = m_xt(a);
    end
    return acc;
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                  ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] m_encrypt(logic [127:0] pt, logic [127:0] key);
    logic [127:0] rk, s, ns;
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    int           src;
    rk = key;
    s  = pt ^ key;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      t = {sbox_t[rk[23:16]], sbox_t[rk[15:8]], sbox_t[rk[7:0]], sbox_t[rk[31:24]]}
          ^ {rc, 24'h0};
      rk[127:96] = rk[127:96] ^ t;
      rk[95:64]  = rk[95:64] ^ rk[127:96];
      rk[63:32]  = rk[63:32] ^ rk[95:64];
      rk[31:0]   = rk[31:0] ^ rk[63:32];
      rc = m_xt(rc);
      for (int i = 0; i < 16; i++) begin
        src = (((i / 4) + (i % 4)) % 4) * 4 + (i % 4);
        ns[127 - 8 * i -: 8] = sbox_t[s[127 - 8 * src -: 8]];
      end
      s = ns;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = s[127 - 32 * c -: 32];
          s[127 - 32 * c -: 32] = {m_xt(a0) ^ m_xt(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ m_xt(a1) ^ m_xt(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ m_xt(a2) ^ m_xt(a3) ^ a3,
                                   m_xt(a0) ^ a0 ^ a1 ^ a2 ^ m_xt(a3)};
        end
      end
      s = s ^ rk;
    end
    return s;
  endfunction

  // ---- driver: wait for both cores idle, capture one block, push expectations ----
  task automatic start_block(input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] pt);
    exp_t        e;
    int unsigned guard = 0;
    @(negedge clk);
    while ((busy || busy_nc || vld || vld_nc) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("idle_wait", 128'(guard < 200), 128'(1));
    din = ct;
    kin = key;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en    = 1'b0;
    e.pt  = pt;
    e.t   = cyc;
    e.lat = (cache_v_m && key == cache_k_m) ? 32'd12 : 32'd22;
    sb.push_back(e);
    e.lat = 32'd22;
    sb_nc.push_back(e);
    cache_v_m = 1'b1;
    cache_k_m = key;
  endtask

  // ---- scoreboard monitors ----
  always @(posedge clk) begin
    #1;
    if (vld) begin
      check_eq("valid_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        m_e = sb.pop_front();
        check_eq("plaintext", dout, m_e.pt);
        check_eq("latency", 128'(cyc - m_e.t), 128'(m_e.lat));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (vld_nc) begin
      check_eq("nc_valid_expected", 128'(sb_nc.size() != 0), 128'(1));
      if (sb_nc.size() != 0) begin
        m_e_nc = sb_nc.pop_front();
        check_eq("nc_plaintext", dout_nc, m_e_nc.pt);
        check_eq("nc_latency", 128'(cyc - m_e_nc.t), 128'(m_e_nc.lat));
      end
    end
  end

  initial begin
    logic         all_busy;
    logic [127:0] key, pt;
    int unsigned  guard;

    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_valid", 128'(vld), 128'(0));
    check_eq("rst_dout", dout, 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // FIPS-197 App. B, cold cache; busy must hold through the DONE cycle
    start_block(CtB, KeyB, PtB);
    all_busy = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      all_busy = all_busy & busy;
    end
    check_eq("busy_hold", 128'(all_busy), 128'(1));
    @(negedge clk);
    check_eq("busy_release", 128'(busy), 128'(0));

    // Key changes force re-expansion; repeated key hits the cache
    start_block(CtC, KeyC, PtC);
    start_block(CtB, KeyB, PtB);
    start_block(CtC, KeyC, PtC);
    start_block(CtC, KeyC, PtC);

    // Enable held and inputs changed while busy: exactly one result, original block
    start_block(CtB, KeyB, PtB);
    guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      en  = 1'b1;
      din = DinAlt;
      kin = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      guard++;
    end
    en = 1'b0;
    check_eq("hold_en_bound", 128'(guard < 100), 128'(1));
    repeat (30) @(negedge clk);
    check_eq("hold_en_drained", 128'(sb.size()), 128'(0));

    // Cache hit block, reset while ROUND counter = 5
    start_block(CtB, KeyB, PtB);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_busy", 128'(busy), 128'(0));
    check_eq("midrst_dout", dout, 128'(0));
    check_eq("midrst_valid", 128'(vld), 128'(0));
    sb.delete();
    sb_nc.delete();
    cache_v_m = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_block(CtB, KeyB, PtB);

    // Random round-trips with mixed key reuse
    key = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(1) == 0) key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      start_block(m_encrypt(pt, key), key, pt);
    end

    guard = 0;
    while ((sb.size() != 0 || sb_nc.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain", 128'(sb.size() + sb_nc.size()), 128'(0));
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
